// File: rtl/matriz_pkg.sv
// Shared definitions for the matriz_loader slice: matrix geometry, FSM states
// and the size check applied to an incoming start.
package matriz_pkg;

    localparam int ELEM_W_DEF = 8;
    localparam int MAT_DIM    = 5;
    localparam int MAX_ORDER  = 5;
    localparam int MAT_W      = MAT_DIM * MAT_DIM * ELEM_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } state_e;

    function automatic logic size_ok(input logic [2:0] s);
        return (s != 3'd0) && (s <= 3'(MAX_ORDER));
    endfunction

endpackage

// File: rtl/matriz_addr_gen.sv
// Row/column/linear counters for an n x n fetch; produces the RAM address and
// the (row, col) slot delayed one cycle to line up with the returning datum.
module matriz_addr_gen
    import matriz_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [2:0]        size_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              cap_valid_o,
    output logic [2:0]        cap_row_o,
    output logic [2:0]        cap_col_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        lim_q, lim_d;
    logic [4:0]        k_q, k_d;
    logic [2:0]        row_q, row_d, col_q, col_d;
    logic              cap_valid_q;
    logic [2:0]        cap_row_q, cap_col_q;

    always_comb begin
        // NOTE: every signal assigned here starts from its held value so no path leaves it unassigned (no latch).
        base_d = base_q;
        lim_d  = lim_q;
        k_d    = k_q;
        row_d  = row_q;
        col_d  = col_q;
        if (load_i) begin
            base_d = base_i;
            lim_d  = size_i - 3'd1;
            k_d    = 5'd0;
            row_d  = 3'd0;
            col_d  = 3'd0;
        end else if (advance_i) begin
            k_d = k_q + 5'd1;
            if (col_q == lim_q) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            base_q      <= '0;
            lim_q       <= '0;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cap_valid_q <= 1'b0;
            cap_row_q   <= '0;
            cap_col_q   <= '0;
        end else begin
            base_q      <= base_d;
            lim_q       <= lim_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cap_valid_q <= advance_i;
            cap_row_q   <= row_q;
            cap_col_q   <= col_q;
        end
    end

    // Address wraps naturally modulo 2^ADDR_W.
    assign addr_o      = base_q + ADDR_W'(k_q);
    assign last_o      = (row_q == lim_q) && (col_q == lim_q);
    assign cap_valid_o = cap_valid_q;
    assign cap_row_o   = cap_row_q;
    assign cap_col_o   = cap_col_q;

endmodule

// File: rtl/matriz_loader.sv
// Fetches an n x n matrix from a synchronous RAM into a zero-padded 5x5 packed
// vector offered on valid/ready. Optional MATRIZ_LOADER_TRANSPOSE_EN adds a transpose input.
module matriz_loader
    import matriz_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int ELEM_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [2:0]                      size,
`ifdef MATRIZ_LOADER_TRANSPOSE_EN
    input  logic                            transpose,
`endif
    output logic                            mem_rd,
    output logic [ADDR_W-1:0]               mem_addr,
    input  logic [ELEM_W-1:0]               mem_rdata,
    output logic [MAT_DIM*MAT_DIM*ELEM_W-1:0] matriz_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            err
);

    localparam int OUT_W = MAT_DIM * MAT_DIM * ELEM_W;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  mat_q, mat_d;
    logic              err_q, err_d;
    logic              accept, reject, last, cap_valid;
    logic [2:0]        cap_row, cap_col, slot_r, slot_c;

    assign accept = (state_q == IDLE) && start && size_ok(size);
    assign reject = (state_q == IDLE) && start && !size_ok(size);

    matriz_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .advance_i   (state_q == READ),
        .base_i      (base_addr),
        .size_i      (size),
        .addr_o      (mem_addr),
        .last_o      (last),
        .cap_valid_o (cap_valid),
        .cap_row_o   (cap_row),
        .cap_col_o   (cap_col)
    );

`ifdef MATRIZ_LOADER_TRANSPOSE_EN
    logic xpose_q;

    always_ff @(posedge clk) begin
        if (!rst_n)      xpose_q <= 1'b0;
        else if (accept) xpose_q <= transpose;
    end

    assign slot_r = xpose_q ? cap_col : cap_row;
    assign slot_c = xpose_q ? cap_row : cap_col;
`else
    assign slot_r = cap_row;
    assign slot_c = cap_col;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = reject;
        unique case (state_q)
            IDLE:    if (accept)    state_d = READ;
            READ:    if (last)      state_d = DRAIN;
            DRAIN:                  state_d = VALID;
            VALID:   if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        mat_d = mat_q;
        if (accept) begin
            mat_d = '0;
        end else if (cap_valid) begin
            for (int r = 0; r < MAT_DIM; r++) begin
                for (int c = 0; c < MAT_DIM; c++) begin
                    if (slot_r == 3'(r) && slot_c == 3'(c))
                        mat_d[(r*MAT_DIM + c)*ELEM_W +: ELEM_W] = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the matrix register is reset because an aborted load must leave zeros, not stale data.
        if (!rst_n) begin
            state_q <= IDLE;
            mat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            err_q   <= err_d;
        end
    end

    assign mem_rd     = (state_q == READ);
    assign out_valid  = (state_q == VALID);
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign matriz_out = mat_q;

endmodule

// File: tb/tb_matriz_loader.sv
// Self-checking bench for matriz_loader: table of loads with an address
// scoreboard, plus hand-written bad-size and reset-abort sequences.
module tb_matriz_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   base_addr;
    logic [2:0]   size;
`ifdef MATRIZ_LOADER_TRANSPOSE_EN
    logic         transpose;
`endif
    logic         mem_rd;
    logic [7:0]   mem_addr;
    logic [7:0]   mem_rdata;
    logic [199:0] matriz_out;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [7:0]   exp_addr_q[$];
    logic [199:0] last_mat;
    logic [7:0]   ram [256];

    typedef struct {
        logic [7:0] base;
        logic [2:0] size;
        int         wait_cyc;
        bit         inject;
        bit         xp;
        int         exp_valid_cyc;
    } vec_t;

    matriz_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .size       (size),
`ifdef MATRIZ_LOADER_TRANSPOSE_EN
        .transpose  (transpose),
`endif
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .matriz_out (matriz_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: data appears the cycle after the read strobe.
    always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // RAM[a] = a+1, so element (i,j) of a load at base holds base+i*n+j+1.
    function automatic logic [199:0] exp_mat(input logic [7:0] base, input int n, input bit xp);
        logic [199:0] m = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                int r = xp ? j : i;
                int c = xp ? i : j;
                m[(r*5 + c)*8 +: 8] = 8'(int'(base) + i*n + j + 1);
            end
        return m;
    endfunction

    task automatic run_load(input vec_t v);
        int n = int'(v.size);
        int cyc = 1;
        int rd_first = 0;
        int rd_cnt = 0;
        logic [7:0]   a;
        logic [199:0] m;
        exp_addr_q.delete();
        for (int k = 0; k < n*n; k++) exp_addr_q.push_back(8'(int'(v.base) + k));
        base_addr = v.base;
        size      = v.size;
`ifdef MATRIZ_LOADER_TRANSPOSE_EN
        transpose = v.xp;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = 8'hA5;
        size = 3'd4;
        while (cyc <= 60 && !out_valid) begin
            if (mem_rd) begin
                rd_cnt++;
                if (rd_first == 0) rd_first = cyc;
                if (exp_addr_q.size() == 0) begin
                    check("extra_read", 1'b1, 1'b0);
                end else begin
                    a = exp_addr_q.pop_front();
                    check("mem_addr", mem_addr, a);
                end
            end
            if (v.inject && cyc == 2) begin
                start = 1'b1; size = 3'd5; base_addr = 8'h77;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("valid_cycle", cyc, v.exp_valid_cyc);
        check("first_read_cycle", rd_first, 1);
        check("read_count", rd_cnt, n*n);
        check("reads_pending", exp_addr_q.size(), 0);
        m = exp_mat(v.base, n, v.xp);
        check("matriz_out", matriz_out, m);
        out_ready = 1'b0;
        for (int w = 0; w < v.wait_cyc; w++) begin
            tick();
            check("hold_valid", out_valid, 1'b1);
            check("hold_matrix", matriz_out, m);
        end
        // Start coincident with the handshake must be ignored.
        out_ready = 1'b1;
        start = 1'b1; size = 3'd3; base_addr = 8'h00;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("valid_after_hs", out_valid, 1'b0);
        check("busy_after_hs", busy, 1'b0);
        check("matrix_after_hs", matriz_out, m);
        last_mat = m;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd"}, mem_rd, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 8'h00);
        check({tag, "_matriz"}, matriz_out, '0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        vec_t vecs[$];
        logic [2:0] bad[3];
        vecs.push_back('{8'h10, 3'd3, 0, 1'b0, 1'b0, 11});
        vecs.push_back('{8'h00, 3'd5, 4, 1'b0, 1'b0, 27});
        vecs.push_back('{8'hFE, 3'd2, 0, 1'b0, 1'b0, 6});
        vecs.push_back('{8'h40, 3'd1, 2, 1'b0, 1'b0, 3});
        vecs.push_back('{8'h80, 3'd4, 0, 1'b1, 1'b0, 18});
`ifdef MATRIZ_LOADER_TRANSPOSE_EN
        vecs.push_back('{8'h10, 3'd3, 1, 1'b0, 1'b1, 11});
        transpose = 1'b0;
`endif
        bad = '{3'd0, 3'd6, 3'd7};
        for (int a = 0; a < 256; a++) ram[a] = 8'(a + 1);

        rst_n = 1'b0; start = 1'b0; base_addr = '0; size = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("reset");
        last_mat = '0;

        foreach (vecs[i]) run_load(vecs[i]);

        // Rejected sizes: one-cycle err, no reads, matrix untouched.
        foreach (bad[i]) begin
            size = bad[i]; base_addr = 8'h20; start = 1'b1;
            tick();
            start = 1'b0;
            check("bad_err", err, 1'b1);
            check("bad_busy", busy, 1'b0);
            check("bad_mem_rd", mem_rd, 1'b0);
            tick();
            check("bad_err_cleared", err, 1'b0);
            check("bad_mem_rd2", mem_rd, 1'b0);
            check("bad_matrix", matriz_out, last_mat);
        end

        // Reset in cycle 5 of a 4x4 load aborts everything on that edge.
        base_addr = 8'h30; size = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_in_read", mem_rd, 1'b1);
        check("abort_addr", mem_addr, 8'h34);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("abort");
        rst_n = 1'b1;
        tick();

        run_load(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
